// File: rtl/frogger_key_pkg.sv
// Shared types and constants for the scripted keyboard source that feeds the frog/arrow decode.
// Key codes are HID usage values, matching what the Nios keycode PIO reports.
package frogger_key_pkg;

    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_FROG1 = 8'h59;
    localparam logic [7:0] KEY_FROG2 = 8'h5A;
    localparam logic [7:0] KEY_FROG3 = 8'h5B;

    localparam int KP_HOLD_W = 6;

    typedef struct packed {
        logic [7:0]           key;
        logic [KP_HOLD_W-1:0] hold;
        logic [KP_HOLD_W-1:0] gap;
    } key_cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } kp_state_t;

    // A zero frame count still means one frame, so the counters never start at zero.
    function automatic logic [KP_HOLD_W-1:0] frames_min1(input logic [KP_HOLD_W-1:0] n);
        return (n == '0) ? KP_HOLD_W'(1) : n;
    endfunction

endpackage

// File: rtl/keycode_player_if.sv
// Command handshake and keycode output bundle between a script source and keycode_player.
// master = command source, slave = the player.
interface keycode_player_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_W     = 6
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [7:0]                    cmd_key;
    logic [HOLD_W-1:0]             cmd_hold;
    logic [HOLD_W-1:0]             cmd_gap;
    logic [15:0]                   keycode;
    logic                          key_strobe;
    logic                          busy;
    logic [$clog2(FIFO_DEPTH):0]   q_count;

    modport master (
        output cmd_valid, cmd_key, cmd_hold, cmd_gap,
        input  cmd_ready, keycode, key_strobe, busy, q_count
    );

    modport slave (
        input  cmd_valid, cmd_key, cmd_hold, cmd_gap,
        output cmd_ready, keycode, key_strobe, busy, q_count
    );
endinterface

// File: rtl/keycode_fifo.sv
// Small synchronous command queue of key_cmd_t entries with registered full/empty/count.
// DEPTH must be a power of two so the pointers wrap on their own.
module keycode_fifo
    import frogger_key_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  key_cmd_t                 wr_data,
    output key_cmd_t                 rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    key_cmd_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               full_reg;
    logic               empty_reg;
    logic               push_ok;
    logic               pop_ok;

    // Push looks only at the registered full flag: a full queue refuses even when popping.
    assign push_ok = push && !full_reg && !flush;
    assign pop_ok  = pop && !empty_reg && !flush;

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok)
            count_next = count_reg + CNT_W'(1);
        else if (pop_ok && !push_ok)
            count_next = count_reg - CNT_W'(1);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];
    assign full    = full_reg;
    assign empty   = empty_reg;
    assign count   = count_reg;

endmodule

// File: rtl/keycode_player.sv
// Replays queued (key, hold, gap) commands as a PIO-compatible 16-bit keycode stream,
// timing presses and releases in VGA frames taken from the asynchronous vsync.
module keycode_player
    import frogger_key_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_W     = KP_HOLD_W
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           frame_clk,
    input  logic           flush,
    keycode_player_if.slave kp
);
    logic                          fclk_meta_reg;
    logic                          fclk_sync_reg;
    logic                          fclk_prev_reg;
    logic                          frame_tick_reg;

    kp_state_t                     state_reg;
    logic [HOLD_W-1:0]             cnt_reg;
    logic [HOLD_W-1:0]             gap_reg;
    logic [7:0]                    key_reg;
    logic                          strobe_reg;

    key_cmd_t                      cmd_in;
    key_cmd_t                      head_cmd;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          pop;
    logic                          last_frame;

    // vsync is unrelated to Clk: two flops for metastability, a third for the edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fclk_meta_reg  <= 1'b0;
            fclk_sync_reg  <= 1'b0;
            fclk_prev_reg  <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            fclk_meta_reg  <= frame_clk;
            fclk_sync_reg  <= fclk_meta_reg;
            fclk_prev_reg  <= fclk_sync_reg;
            frame_tick_reg <= fclk_sync_reg && !fclk_prev_reg;
        end
    end

    assign cmd_in.key  = kp.cmd_key;
    assign cmd_in.hold = kp.cmd_hold;
    assign cmd_in.gap  = kp.cmd_gap;

    keycode_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .flush   (flush),
        .push    (kp.cmd_valid),
        .pop     (pop),
        .wr_data (cmd_in),
        .rd_data (head_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign last_frame = (cnt_reg <= HOLD_W'(1));

    // A new command loads from IDLE, or straight out of the last release frame.
    assign pop = frame_tick_reg && !flush && !fifo_empty &&
                 ((state_reg == IDLE) || ((state_reg == RELEASE) && last_frame));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            gap_reg    <= '0;
            key_reg    <= 8'h00;
            strobe_reg <= 1'b0;
        end else begin
            strobe_reg <= 1'b0;
            if (flush) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                key_reg   <= 8'h00;
            end else if (pop) begin
                state_reg  <= PRESS;
                key_reg    <= head_cmd.key;
                cnt_reg    <= frames_min1(head_cmd.hold);
                gap_reg    <= frames_min1(head_cmd.gap);
                strobe_reg <= (head_cmd.key != 8'h00);
            end else if (frame_tick_reg) begin
                case (state_reg)
                    PRESS: begin
                        if (!last_frame) begin
                            cnt_reg <= cnt_reg - HOLD_W'(1);
                        end else begin
                            key_reg   <= 8'h00;
                            cnt_reg   <= gap_reg;
                            state_reg <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (!last_frame)
                            cnt_reg <= cnt_reg - HOLD_W'(1);
                        else
                            state_reg <= IDLE;
                    end
                    IDLE:    state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign kp.cmd_ready  = !fifo_full;
    assign kp.keycode    = {8'h00, key_reg};
    assign kp.key_strobe = strobe_reg;
    assign kp.busy       = (state_reg != IDLE) || !fifo_empty;
    assign kp.q_count    = fifo_count;

endmodule

// File: tb/tb_keycode_player.sv
// Directed bench for keycode_player: frame-timed replay, back-to-back keys, full queue,
// pure delays, flush and asynchronous reset.
module tb_keycode_player;
    import frogger_key_pkg::*;

    logic clk;
    logic rst_n;
    logic frame_clk;
    logic flush;
    int   tests_run;
    int   tests_failed;
    int   strobe_cnt;
    int   s0;

    keycode_player_if #(.FIFO_DEPTH(4), .HOLD_W(6)) bus ();

    keycode_player #(
        .FIFO_DEPTH (4),
        .HOLD_W     (6)
    ) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .frame_clk (frame_clk),
        .flush     (flush),
        .kp        (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bus.key_strobe)
            strobe_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    // One frame: rising edge at an offset unrelated to clk, enough cycles to settle.
    task automatic do_frame();
        #3 frame_clk = 1'b1;
        repeat (6) @(posedge clk);
        #1 frame_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] k, input logic [5:0] h, input logic [5:0] g);
        int n;
        n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.cmd_ready)
            check("push_ready_timeout", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = k;
        bus.cmd_hold  = h;
        bus.cmd_gap   = g;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    logic [7:0]  t3_keys [5];
    logic [15:0] t3_exp  [10];

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        strobe_cnt    = 0;
        rst_n         = 1'b0;
        frame_clk     = 1'b0;
        flush         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_key   = 8'h00;
        bus.cmd_hold  = '0;
        bus.cmd_gap   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_keycode",   32'(bus.keycode),    32'h0);
        check("rst_strobe",    32'(bus.key_strobe), 32'h0);
        check("rst_busy",      32'(bus.busy),       32'h0);
        check("rst_cmd_ready", 32'(bus.cmd_ready),  32'h1);
        check("rst_q_count",   32'(bus.q_count),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single key, hold 2, gap 1
        s0 = strobe_cnt;
        push_cmd(KEY_UP, 6'd2, 6'd1);
        check("t1_pre_keycode", 32'(bus.keycode), 32'h0);
        check("t1_pre_busy",    32'(bus.busy),    32'h1);
        do_frame();
        check("t1_f1_keycode", 32'(bus.keycode), 32'h0052);
        do_frame();
        check("t1_f2_keycode", 32'(bus.keycode), 32'h0052);
        do_frame();
        check("t1_f3_keycode", 32'(bus.keycode), 32'h0000);
        check("t1_f3_busy",    32'(bus.busy),    32'h1);
        do_frame();
        check("t1_f4_keycode", 32'(bus.keycode), 32'h0000);
        check("t1_f4_busy",    32'(bus.busy),    32'h0);
        check("t1_strobes",    32'(strobe_cnt - s0), 32'd1);

        // 2: identical keys back to back stay separated by a release
        s0 = strobe_cnt;
        push_cmd(KEY_RIGHT, 6'd1, 6'd1);
        push_cmd(KEY_RIGHT, 6'd1, 6'd1);
        do_frame(); check("t2_f1", 32'(bus.keycode), 32'h004F);
        do_frame(); check("t2_f2", 32'(bus.keycode), 32'h0000);
        do_frame(); check("t2_f3", 32'(bus.keycode), 32'h004F);
        do_frame(); check("t2_f4", 32'(bus.keycode), 32'h0000);
        do_frame(); check("t2_idle_busy", 32'(bus.busy), 32'h0);
        check("t2_strobes", 32'(strobe_cnt - s0), 32'd2);

        // 3: five commands into a four-deep queue
        s0 = strobe_cnt;
        t3_keys = '{KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP, KEY_FROG1};
        t3_exp  = '{16'h004F, 16'h0000, 16'h0050, 16'h0000, 16'h0051,
                    16'h0000, 16'h0052, 16'h0000, 16'h0059, 16'h0000};
        for (int i = 0; i < 4; i++)
            push_cmd(t3_keys[i], 6'd1, 6'd0);
        check("t3_full_ready", 32'(bus.cmd_ready), 32'h0);
        check("t3_full_count", 32'(bus.q_count),   32'd4);
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = t3_keys[4];
        bus.cmd_hold  = 6'd0;
        bus.cmd_gap   = 6'd1;
        repeat (2) @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        check("t3_held_off_count", 32'(bus.q_count), 32'd4);
        do_frame();
        check("t3_f1_keycode",     32'(bus.keycode),   32'(t3_exp[0]));
        check("t3_after_pop_cnt",  32'(bus.q_count),   32'd3);
        check("t3_after_pop_rdy",  32'(bus.cmd_ready), 32'h1);
        push_cmd(t3_keys[4], 6'd0, 6'd1);
        check("t3_refill_count", 32'(bus.q_count), 32'd4);
        for (int f = 1; f < 10; f++) begin
            do_frame();
            check($sformatf("t3_f%0d_keycode", f + 1), 32'(bus.keycode), 32'(t3_exp[f]));
        end
        do_frame();
        check("t3_end_busy",  32'(bus.busy),          32'h0);
        check("t3_end_count", 32'(bus.q_count),       32'd0);
        check("t3_strobes",   32'(strobe_cnt - s0),   32'd5);

        // 4: pure delay then a key
        s0 = strobe_cnt;
        push_cmd(8'h00, 6'd3, 6'd1);
        push_cmd(KEY_LEFT, 6'd1, 6'd1);
        for (int f = 0; f < 4; f++) begin
            do_frame();
            check($sformatf("t4_delay_f%0d", f + 1), 32'(bus.keycode), 32'h0);
        end
        do_frame();
        check("t4_f5_keycode", 32'(bus.keycode), 32'h0050);
        do_frame();
        do_frame();
        check("t4_strobes", 32'(strobe_cnt - s0), 32'd1);
        check("t4_end_busy", 32'(bus.busy), 32'h0);

        // 5: flush in the middle of a press with two queued
        push_cmd(KEY_DOWN, 6'd5, 6'd1);
        push_cmd(KEY_RIGHT, 6'd1, 6'd1);
        push_cmd(KEY_LEFT, 6'd1, 6'd1);
        do_frame();
        check("t5_press_keycode", 32'(bus.keycode), 32'h0051);
        check("t5_press_count",   32'(bus.q_count), 32'd2);
        s0 = strobe_cnt;
        flush         = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_key   = KEY_UP;
        bus.cmd_hold  = 6'd1;
        bus.cmd_gap   = 6'd1;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        bus.cmd_valid = 1'b0;
        check("t5_flush_keycode", 32'(bus.keycode), 32'h0);
        check("t5_flush_count",   32'(bus.q_count), 32'd0);
        check("t5_flush_busy",    32'(bus.busy),    32'h0);
        for (int f = 0; f < 3; f++)
            do_frame();
        check("t5_after_keycode", 32'(bus.keycode),      32'h0);
        check("t5_after_strobes", 32'(strobe_cnt - s0),  32'd0);

        // 6: asynchronous reset while a key is held
        push_cmd(KEY_LEFT, 6'd5, 6'd1);
        push_cmd(KEY_RIGHT, 6'd1, 6'd1);
        do_frame();
        check("t6_press_keycode", 32'(bus.keycode), 32'h0050);
        #3 rst_n = 1'b0;
        #1;
        check("t6_async_keycode", 32'(bus.keycode), 32'h0);
        repeat (3) @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rel_ready", 32'(bus.cmd_ready), 32'h1);
        check("t6_rel_count", 32'(bus.q_count),   32'd0);
        check("t6_rel_busy",  32'(bus.busy),      32'h0);
        s0 = strobe_cnt;
        push_cmd(KEY_UP, 6'd1, 6'd1);
        do_frame();
        check("t6_tick_keycode", 32'(bus.keycode), 32'h0052);
        check("t6_tick_strobes", 32'(strobe_cnt - s0), 32'd1);
        do_frame();
        check("t6_tick2_keycode", 32'(bus.keycode), 32'h0);
        do_frame();
        check("t6_tick3_busy", 32'(bus.busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
